// File: rtl/mem_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter_if
//
// Bundles every signal between the IF/MEM pipeline stages, the arbiter and the
// single-ported RAM. clk and rst stay plain ports on the modules.
//
//   Pipeline IF side : if_req, if_addr, flush       -> arbiter
//                      if_rdata, if_valid, if_freeze <- arbiter
//   Pipeline MEM side: mem_req, mem_we, mem_addr, mem_wdata -> arbiter
//                      mem_rdata, mem_valid, mem_freeze     <- arbiter
//   RAM side         : ram_req, ram_we, ram_addr, ram_wdata <- arbiter
//                      ram_rdata, ram_ready                 -> arbiter
//
// Modports:
//   slave  - the arbiter's view
//   master - the environment's view (pipeline stages plus RAM)
// ----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int WORD_LEN = 16
) ();

    // Fetch stage
    logic                if_req;
    logic [WORD_LEN-1:0] if_addr;
    logic [WORD_LEN-1:0] if_rdata;
    logic                if_valid;
    logic                if_freeze;
    logic                flush;

    // Memory stage
    logic                mem_req;
    logic                mem_we;
    logic [WORD_LEN-1:0] mem_addr;
    logic [WORD_LEN-1:0] mem_wdata;
    logic [WORD_LEN-1:0] mem_rdata;
    logic                mem_valid;
    logic                mem_freeze;

    // RAM
    logic                ram_req;
    logic                ram_we;
    logic [WORD_LEN-1:0] ram_addr;
    logic [WORD_LEN-1:0] ram_wdata;
    logic [WORD_LEN-1:0] ram_rdata;
    logic                ram_ready;

    modport slave (
        input  if_req, if_addr, flush,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  ram_rdata, ram_ready,
        output if_rdata, if_valid, if_freeze,
        output mem_rdata, mem_valid, mem_freeze,
        output ram_req, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output if_req, if_addr, flush,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output ram_rdata, ram_ready,
        input  if_rdata, if_valid, if_freeze,
        input  mem_rdata, mem_valid, mem_freeze,
        input  ram_req, ram_we, ram_addr, ram_wdata
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported RAM between the fetch stage (IF) and the memory
// stage (MEM). One access is in flight at a time; the RAM strobe and its
// address/data are registered and held until ram_ready. Completion is reported
// with a one-cycle valid pulse per port, and each port gets a freeze signal
// while its request is outstanding.
//
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-low reset
//   bus  - mem_port_arbiter_if.slave: IF request/response + flush,
//          MEM request/response, RAM strobe/address/data/ready
//
// Parameters:
//   WORD_LEN     - address and data width
//   STARVE_LIMIT - consecutive MEM grants tolerated while IF waits (1..15)
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int WORD_LEN     = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        IF_BUSY,
        MEM_BUSY,
        DONE
    } state_e;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_e              state_q;
    logic [3:0]          starve_q;
    logic                drop_q;

    logic                ram_req_q;
    logic                ram_we_q;
    logic [WORD_LEN-1:0] ram_addr_q;
    logic [WORD_LEN-1:0] ram_wdata_q;
    logic [WORD_LEN-1:0] if_rdata_q;
    logic [WORD_LEN-1:0] mem_rdata_q;
    logic                if_valid_q;
    logic                mem_valid_q;

    // Grant decision, only acted on in IDLE. MEM has priority until IF has
    // watched STARVE_LIMIT MEM grants go by; a flushed fetch address is stale,
    // so IF is never granted in a cycle that carries flush.
    logic grant_mem;
    logic grant_if;
    // Fetch result is thrown away if a flush arrived earlier in the access or
    // arrives in the very cycle the RAM answers.
    logic if_drop;

    assign grant_mem = bus.mem_req && (!bus.if_req || (starve_q < STARVE_MAX));
    assign grant_if  = !grant_mem && bus.if_req && !bus.flush;
    assign if_drop   = drop_q || bus.flush;

    always_ff @(posedge clk) begin
        // NOTE: every state register here uses <= so that all of them see the
        // pre-edge values; a blocking = would let later statements read the
        // already-updated value and break the one-cycle timing.
        if (!rst) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            drop_q      <= 1'b0;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_valid_q  <= 1'b0;
            mem_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_mem) begin
                        ram_req_q   <= 1'b1;
                        ram_we_q    <= bus.mem_we;
                        ram_addr_q  <= bus.mem_addr;
                        ram_wdata_q <= bus.mem_wdata;
                        state_q     <= MEM_BUSY;
                        // grant_mem with if_req pending implies starve_q is
                        // still below the limit, so this saturates by itself.
                        if (bus.if_req) begin
                            starve_q <= starve_q + 4'd1;
                        end
                    end else if (grant_if) begin
                        ram_req_q  <= 1'b1;
                        ram_we_q   <= 1'b0;
                        ram_addr_q <= bus.if_addr;
                        starve_q   <= '0;
                        state_q    <= IF_BUSY;
                    end
                end

                IF_BUSY: begin
                    if (bus.flush) begin
                        drop_q <= 1'b1;
                    end
                    if (bus.ram_ready) begin
                        ram_req_q <= 1'b0;
                        state_q   <= DONE;
                        if (!if_drop) begin
                            if_valid_q <= 1'b1;
                            if_rdata_q <= bus.ram_rdata;
                        end
                    end
                end

                MEM_BUSY: begin
                    if (bus.ram_ready) begin
                        ram_req_q   <= 1'b0;
                        mem_valid_q <= 1'b1;
                        state_q     <= DONE;
                        // Writes complete without touching the read register.
                        if (!ram_we_q) begin
                            mem_rdata_q <= bus.ram_rdata;
                        end
                    end
                end

                DONE: begin
                    if_valid_q  <= 1'b0;
                    mem_valid_q <= 1'b0;
                    drop_q      <= 1'b0;
                    state_q     <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ram_req   = ram_req_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.mem_valid = mem_valid_q;

    // Freeze depends only on the request inputs and the registered valids,
    // never on the RAM handshake.
    assign bus.if_freeze  = bus.if_req & ~if_valid_q;
    assign bus.mem_freeze = bus.mem_req & ~mem_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Drives the arbiter with directed scenarios and then random traffic from two
// requesters and a RAM with random latency. A transaction-level reference
// model predicts every output each cycle; directed scenarios also pin
// hand-computed literal values. A second instance with STARVE_LIMIT=1 runs
// permanent contention and must alternate grants.
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int WL    = 16;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst;

    mem_port_arbiter_if #(.WORD_LEN(WL)) bus  ();
    mem_port_arbiter_if #(.WORD_LEN(WL)) bus1 ();

    mem_port_arbiter #(.WORD_LEN(WL), .STARVE_LIMIT(LIMIT)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mem_port_arbiter #(.WORD_LEN(WL), .STARVE_LIMIT(1)) u_dut_lim1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // RAM responder: answers each strobe after a per-access latency.
    // Outside a strobe, random mode drives noise on ready/rdata.
    // ------------------------------------------------------------------
    bit          rand_mode = 1'b0;
    int          fix_lat   = 0;
    logic [15:0] fix_data  = 16'h0;

    initial begin
        int r_wait;
        int r_lat;
        r_wait = 0;
        r_lat  = 0;
        bus.ram_ready = 1'b0;
        bus.ram_rdata = 16'h0;
        forever begin
            @(negedge clk);
            if (bus.ram_req === 1'b1) begin
                if (r_wait == 0) r_lat = rand_mode ? int'($urandom_range(0, 3)) : fix_lat;
                if (r_wait == r_lat) begin
                    bus.ram_ready = 1'b1;
                    bus.ram_rdata = rand_mode ? 16'($urandom) : fix_data;
                end else begin
                    bus.ram_ready = 1'b0;
                    bus.ram_rdata = rand_mode ? 16'($urandom) : 16'h0;
                end
                r_wait++;
            end else begin
                r_wait = 0;
                bus.ram_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.ram_rdata = rand_mode ? 16'($urandom) : 16'h0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model: tracks the single outstanding access as a record
    // (who, address, data, dropped) plus a "result cycle" flag.
    // ------------------------------------------------------------------
    bit          m_live = 1'b0;
    bit          m_busy, m_fin, m_is_mem, m_drop;
    int          m_starve;
    logic        e_ram_req, e_ram_we, e_if_valid, e_mem_valid;
    logic [15:0] e_ram_addr, e_ram_wdata, e_if_rdata, e_mem_rdata;

    initial begin
        bit mem_wins;
        forever begin
            @(posedge clk);
            if (rst === 1'b0) begin
                m_live = 1'b1;
                m_busy = 1'b0; m_fin = 1'b0; m_drop = 1'b0; m_is_mem = 1'b0;
                m_starve = 0;
                e_ram_req = 1'b0; e_ram_we = 1'b0; e_ram_addr = 16'h0; e_ram_wdata = 16'h0;
                e_if_rdata = 16'h0; e_mem_rdata = 16'h0; e_if_valid = 1'b0; e_mem_valid = 1'b0;
            end else if (m_live) begin
                e_if_valid  = 1'b0;
                e_mem_valid = 1'b0;
                if (m_fin) begin
                    m_fin = 1'b0;                    // result cycle over, next cycle accepts requests
                end else if (m_busy) begin
                    if (!m_is_mem && bus.flush) m_drop = 1'b1;
                    if (bus.ram_ready) begin
                        m_busy = 1'b0;
                        m_fin  = 1'b1;
                        e_ram_req = 1'b0;
                        if (m_is_mem) begin
                            e_mem_valid = 1'b1;
                            if (!e_ram_we) e_mem_rdata = bus.ram_rdata;
                        end else if (!m_drop) begin
                            e_if_valid = 1'b1;
                            e_if_rdata = bus.ram_rdata;
                        end
                        m_drop = 1'b0;
                    end
                end else begin
                    mem_wins = bus.mem_req && (!bus.if_req || m_starve < LIMIT);
                    if (mem_wins) begin
                        m_busy = 1'b1; m_is_mem = 1'b1;
                        e_ram_req = 1'b1; e_ram_we = bus.mem_we;
                        e_ram_addr = bus.mem_addr; e_ram_wdata = bus.mem_wdata;
                        if (bus.if_req) m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
                    end else if (bus.if_req && !bus.flush) begin
                        m_busy = 1'b1; m_is_mem = 1'b0;
                        e_ram_req = 1'b1; e_ram_we = 1'b0;
                        e_ram_addr = bus.if_addr;
                        m_starve = 0;
                    end
                end
            end
        end
    end

    // Compare every cycle, one time unit after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (m_live) begin
                check("ram_req",   bus.ram_req,   e_ram_req);
                check("ram_we",    bus.ram_we,    e_ram_we);
                check("ram_addr",  bus.ram_addr,  e_ram_addr);
                if (e_ram_we) check("ram_wdata", bus.ram_wdata, e_ram_wdata);
                check("if_valid",  bus.if_valid,  e_if_valid);
                check("if_rdata",  bus.if_rdata,  e_if_rdata);
                check("mem_valid", bus.mem_valid, e_mem_valid);
                check("mem_rdata", bus.mem_rdata, e_mem_rdata);
                check("if_freeze",  bus.if_freeze,  bus.if_req  & ~e_if_valid);
                check("mem_freeze", bus.mem_freeze, bus.mem_req & ~e_mem_valid);
            end
        end
    end

    // ------------------------------------------------------------------
    // STARVE_LIMIT=1 instance under permanent contention: grants alternate.
    // ------------------------------------------------------------------
    initial begin
        bit   lim_seq [12];
        int   n_g;
        logic prev;
        bus1.if_req = 1'b1;  bus1.if_addr = 16'h0040; bus1.flush = 1'b0;
        bus1.mem_req = 1'b1; bus1.mem_we = 1'b0; bus1.mem_addr = 16'h0100; bus1.mem_wdata = 16'h0;
        bus1.ram_ready = 1'b1; bus1.ram_rdata = 16'h0;
        n_g  = 0;
        prev = 1'b0;
        wait (rst === 1'b1);
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (bus1.ram_req && !prev && n_g < 12) begin
                lim_seq[n_g] = (bus1.ram_addr == 16'h0100);
                n_g++;
            end
            prev = bus1.ram_req;
        end
        check("lim1 grant count >= 8", (n_g >= 8), 1);
        for (int i = 0; i < 8; i++) check($sformatf("lim1 grant %0d is MEM", i), lim_seq[i], (i % 2 == 0));
    end

    // ------------------------------------------------------------------
    // Directed helpers
    // ------------------------------------------------------------------
    task automatic quiesce();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 12 && !done; k++) begin
            @(negedge clk);
            if (bus.if_valid || bus.mem_valid) begin
                bus.if_req  = 1'b0;
                bus.mem_req = 1'b0;
                done = 1'b1;
            end
        end
        check("quiesce completion seen", done, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic mem_txn(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                           output int pulses, output logic g_we, output logic [15:0] g_addr,
                           output logic [15:0] g_wdata, output logic [15:0] rdata_at_valid);
        bit seen;
        seen = 1'b0; pulses = 0;
        g_we = 1'b0; g_addr = 16'h0; g_wdata = 16'h0; rdata_at_valid = 16'h0;
        bus.mem_we = we; bus.mem_addr = addr; bus.mem_wdata = wdata; bus.mem_req = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (bus.ram_req && !seen) begin
                seen = 1'b1;
                g_we = bus.ram_we; g_addr = bus.ram_addr; g_wdata = bus.ram_wdata;
            end
            if (bus.mem_valid) begin
                pulses++;
                rdata_at_valid = bus.mem_rdata;
            end
            @(negedge clk);
            if (pulses > 0) bus.mem_req = 1'b0;
        end
    endtask

    // ------------------------------------------------------------------
    // Main stimulus
    // ------------------------------------------------------------------
    bit exp_seq [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    bit got_seq [10];

    initial begin
        int          n_g, pulses, vcyc, mv, rq;
        bit          seen;
        logic        prev_req, g_we;
        logic [15:0] g_addr, g_wdata, rd, vrd;
        logic [15:0] gaddr [4];

        rst = 1'b0;
        bus.if_req = 1'b1;  bus.if_addr = 16'h0040; bus.flush = 1'b0;
        bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = 16'h0100; bus.mem_wdata = 16'h0;

        // Reset held two cycles with both requests high.
        repeat (2) begin
            @(posedge clk);
            #1;
            check("reset ram_req",   bus.ram_req,   0);
            check("reset ram_we",    bus.ram_we,    0);
            check("reset ram_addr",  bus.ram_addr,  0);
            check("reset ram_wdata", bus.ram_wdata, 0);
            check("reset if_valid",  bus.if_valid,  0);
            check("reset mem_valid", bus.mem_valid, 0);
            check("reset if_rdata",  bus.if_rdata,  0);
            check("reset mem_rdata", bus.mem_rdata, 0);
        end

        // Contention: MEM x4 then IF, repeating; immediate RAM.
        fix_lat = 0;
        @(negedge clk);
        rst = 1'b1;
        prev_req = 1'b0;
        n_g = 0;
        for (int k = 0; k < 40 && n_g < 10; k++) begin
            @(posedge clk);
            #1;
            if (bus.ram_req && !prev_req) begin
                if (n_g == 0) begin
                    check("first grant after reset is MEM", bus.ram_addr, 16'h0100);
                    check("first grant on first edge", k, 0);
                end
                got_seq[n_g] = (bus.ram_addr == 16'h0100);
                n_g++;
            end
            prev_req = bus.ram_req;
        end
        check("contention grant count", n_g, 10);
        for (int i = 0; i < 10; i++) check($sformatf("contention grant %0d is MEM", i), got_seq[i], exp_seq[i]);
        quiesce();

        // IF read, RAM answers two cycles after the strobe rises.
        fix_lat = 2; fix_data = 16'h1234;
        bus.if_addr = 16'h0004; bus.if_req = 1'b1;
        pulses = 0; vcyc = -1; seen = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (bus.ram_req && !seen) begin
                seen = 1'b1;
                check("IF read ram_addr", bus.ram_addr, 16'h0004);
                check("IF read ram_we", bus.ram_we, 0);
                check("IF read grant cycle", k, 1);
            end
            if (bus.if_valid) begin
                pulses++;
                vcyc = k;
                check("IF read if_rdata", bus.if_rdata, 16'h1234);
                check("IF freeze low at valid", bus.if_freeze, 0);
            end else if (pulses == 0) begin
                check("IF freeze while waiting", bus.if_freeze, 1);
            end
            @(negedge clk);
            if (pulses > 0) bus.if_req = 1'b0;
        end
        check("IF read valid pulses", pulses, 1);
        check("IF read valid cycle", vcyc, 4);

        // MEM read to give mem_rdata a known value, then a write.
        fix_lat = 1; fix_data = 16'h5A5A;
        mem_txn(1'b0, 16'h0300, 16'h0, pulses, g_we, g_addr, g_wdata, rd);
        check("MEM read pulses", pulses, 1);
        check("MEM read mem_rdata", rd, 16'h5A5A);
        fix_data = 16'hC3C3;
        mem_txn(1'b1, 16'h0200, 16'hBEEF, pulses, g_we, g_addr, g_wdata, rd);
        check("write ram_we", g_we, 1);
        check("write ram_addr", g_addr, 16'h0200);
        check("write ram_wdata", g_wdata, 16'hBEEF);
        check("write mem_valid pulses", pulses, 1);
        check("write keeps mem_rdata", rd, 16'h5A5A);

        // Flush while the fetch is in flight.
        fix_lat = 2; fix_data = 16'hAAAA;
        bus.if_addr = 16'h0010; bus.if_req = 1'b1; bus.mem_we = 1'b0;
        n_g = 0; pulses = 0; prev_req = 1'b0; vrd = 16'h0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            if (bus.ram_req && !prev_req && n_g < 4) begin
                gaddr[n_g] = bus.ram_addr;
                n_g++;
            end
            prev_req = bus.ram_req;
            if (k == 4) begin
                check("flush: dropped access finished on RAM", bus.ram_req, 0);
                check("flush: if_rdata kept", bus.if_rdata, 16'h1234);
            end
            if (bus.if_valid) begin
                pulses++;
                vrd = bus.if_rdata;
            end
            @(negedge clk);
            if (k == 1) bus.flush = 1'b1;
            if (k == 2) begin
                bus.flush = 1'b0;
                bus.if_addr = 16'h0020;
            end
            if (k == 4) fix_data = 16'h7777;
            if (pulses > 0) bus.if_req = 1'b0;
        end
        check("flush: grant count", n_g, 2);
        check("flush: first fetch addr", gaddr[0], 16'h0010);
        check("flush: refetch addr", gaddr[1], 16'h0020);
        check("flush: if_valid pulses", pulses, 1);
        check("flush: refetch data", vrd, 16'h7777);

        // Reset in the middle of a MEM access.
        fix_lat = 3; fix_data = 16'h9999;
        bus.mem_we = 1'b0; bus.mem_addr = 16'h0400; bus.mem_req = 1'b1;
        @(posedge clk);
        #1;
        check("rst-mid: MEM granted", bus.ram_req, 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst-mid: ram_req dropped", bus.ram_req, 0);
        check("rst-mid: no mem_valid", bus.mem_valid, 0);
        check("rst-mid: mem_rdata cleared", bus.mem_rdata, 0);
        @(negedge clk);
        bus.mem_req = 1'b0;
        rst = 1'b1;
        mv = 0; rq = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (bus.mem_valid) mv++;
            if (bus.ram_req) rq++;
        end
        check("rst-mid: no late mem_valid", mv, 0);
        check("rst-mid: RAM stays idle", rq, 0);

        // Random traffic with occasional resets.
        rand_mode = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            rst = (cyc % 600 == 599) ? 1'b0 : 1'b1;
            if (bus.if_req && bus.if_valid) begin
                if ($urandom_range(0, 1) == 1) bus.if_addr = 16'($urandom);
                else bus.if_req = 1'b0;
            end else if (!bus.if_req && $urandom_range(0, 2) == 0) begin
                bus.if_req = 1'b1;
                bus.if_addr = 16'($urandom);
            end
            bus.flush = ($urandom_range(0, 7) == 0);
            if (bus.flush && bus.if_req) bus.if_addr = 16'($urandom);
            if (bus.mem_req && bus.mem_valid) begin
                if ($urandom_range(0, 1) == 1) begin
                    bus.mem_we = 1'($urandom_range(0, 1));
                    bus.mem_addr = 16'($urandom);
                    bus.mem_wdata = 16'($urandom);
                end else begin
                    bus.mem_req = 1'b0;
                end
            end else if (!bus.mem_req && $urandom_range(0, 2) == 0) begin
                bus.mem_req = 1'b1;
                bus.mem_we = 1'($urandom_range(0, 1));
                bus.mem_addr = 16'($urandom);
                bus.mem_wdata = 16'($urandom);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        bus.flush = 1'b0;
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported 16-bit instruction/data RAM between two requesters: the fetch stage (IF) and the memory stage (MEM).
- Grants one access at a time and holds the RAM request until the RAM acknowledges.
- Returns read data to the winning port and produces per-port freeze signals that stall the losing or waiting stage.
- Sits between the pipeline stages and the RAM; `flush` (branch/jump taken) cancels an in-flight fetch.

Parameters:
- WORD_LEN, 16, data and address width.
- STARVE_LIMIT, 4, consecutive MEM grants allowed while if_req is pending before IF is forced next; range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset; sampled on rising edge of clk.
- if_req  in  1  fetch request; held high with if_addr stable until if_valid.
- if_addr  in  WORD_LEN  fetch address (PC).
- if_rdata  out  WORD_LEN  fetched instruction; valid when if_valid=1.
- if_valid  out  1  one-cycle completion pulse for IF.
- if_freeze  out  1  stall IF stage.
- flush  in  1  branch/jump redirect; cancels pending or in-flight IF access.
- mem_req  in  1  data access request; held with address/data stable until mem_valid.
- mem_we  in  1  1=write, 0=read.
- mem_addr  in  WORD_LEN  data address.
- mem_wdata  in  WORD_LEN  write data.
- mem_rdata  out  WORD_LEN  read data; updated only on read completion.
- mem_valid  out  1  one-cycle completion pulse for MEM; reads and writes.
- mem_freeze  out  1  stall MEM and earlier stages.
- ram_req  out  1  RAM access strobe, registered.
- ram_we  out  1  RAM write enable, registered.
- ram_addr  out  WORD_LEN  RAM address, registered.
- ram_wdata  out  WORD_LEN  RAM write data, registered.
- ram_rdata  in  WORD_LEN  RAM read data; valid with ram_ready.
- ram_ready  in  1  RAM acknowledge; meaningful only while ram_req=1.

Behaviour:
- **Reset** (rst=0 at edge):
  - State becomes IDLE; starve counter=0; drop flag=0.
  - ram_req, ram_we, ram_addr, ram_wdata, if_rdata, mem_rdata, if_valid and mem_valid all become 0.
  - Reset mid-access abandons the access; ram_req is 0 the next cycle. The RAM tolerates abandoned requests.
- **States:** IDLE, IF_BUSY, MEM_BUSY, DONE.
- **IDLE:** requests are sampled only here. Grant order:
  - MEM wins if mem_req=1 and (if_req=0 or starve<STARVE_LIMIT).
  - Otherwise IF wins if if_req=1 and flush=0.
  - If flush=1 in IDLE, IF is not granted that cycle, because its address is stale.
  - On a grant, ram_req/ram_we/ram_addr/ram_wdata are loaded; next state is IF_BUSY or MEM_BUSY.
  - For an IF grant, ram_we=0.
- **Starve counter:**
  - Increments on each MEM grant made while if_req=1, saturating at STARVE_LIMIT.
  - Clears on each IF grant.
- **BUSY states:** RAM outputs are held until ram_ready=1. On ready:
  - ram_req drops to 0 and read data is captured.
  - A valid pulse is registered; next state is DONE.
- **DONE:** the valid pulse is high for exactly this cycle; next state is IDLE.
- **Latency:**
  - Grant in cycle N; ram_req high from N+1.
  - ram_ready in cycle M≥N+1; valid in M+1.
  - Earliest next grant in M+2, so the earliest round trip is 3 cycles.
- **Flush:**
  - In IF_BUSY, flush sets the drop flag. The access still completes on the RAM, but if_valid is suppressed and if_rdata is unchanged. The flag clears on DONE.
  - In MEM_BUSY or DONE, flush has no effect on MEM.
- **Freeze:**
  - if_freeze = if_req & ~if_valid.
  - mem_freeze = mem_req & ~mem_valid.
  - Both are combinational from inputs and registered valids. No combinational path from ram_* to freeze.
- **Writes:** mem_valid pulses on write completion; mem_rdata is unchanged.
- **Idle requests:** if_req=mem_req=0 in IDLE keeps ram_req=0 and the counter is unchanged.

Test Plan:
- Reset: hold rst=0 for 2 cycles with both requests high → all outputs 0, no ram_req; release → MEM granted first.
- IF read: if_req=1, if_addr=0x0004, RAM returns 0x1234 with ready 2 cycles after ram_req → ram_addr=0x0004, if_valid pulses once with if_rdata=0x1234; if_freeze high until that cycle.
- Contention: if_req and mem_req both held, MEM does repeated reads (mem_addr=0x0100), ready always immediate → sequence is MEM×4 then IF then MEM×4…; with STARVE_LIMIT=1 grants alternate.
- Write: mem_we=1, mem_addr=0x0200, mem_wdata=0xBEEF → ram_we=1, ram_wdata=0xBEEF; mem_valid pulses; mem_rdata retains its prior value.
- Flush in flight: IF granted for 0x0010, flush pulsed in IF_BUSY, RAM returns 0xAAAA → no if_valid, if_rdata unchanged; next IF grant uses the new if_addr=0x0020.
- Reset mid-access: rst=0 during MEM_BUSY → ram_req=0 the next cycle, no mem_valid, state IDLE, counter 0.
